kia_host_tx: RTL and testbench

// PS/2 host-to-device transmitter; companion to the KIA keyboard receiver. The CPU writes a

---
 rtl/kia_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_kia_host_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kia_host_tx.sv
// PS/2 host-to-device transmitter with a Wishbone slave. Sends one command byte per frame
// and reports device ACK, NAK or timeout in a status register.
module kia_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int CNT_W          = 19
) (
  input  logic       CLK_I,
  input  logic       RES_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic       ADR_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  input  logic       C_I,
  input  logic       D_I,
  output logic       C_OE_O,
  output logic       D_OE_O,
  output logic       rx_inhibit_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_BITS    = 3'd2;
  localparam logic [2:0] S_ACKW    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [7:0]       data_reg;
  logic [8:0]       shift_reg;
  logic             ovr_reg, tmo_reg, nak_reg, ackd_reg;
  logic             prev_c_reg;

  logic [1:0] line_in, line_sync;
  logic       c_sync, d_sync, fall;

  assign line_in = {D_I, C_I};

  // Synchronisers reset to the idle (high) bus level so reset never fakes a falling edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg, sync_reg;
      always_ff @(posedge CLK_I or posedge RES_I) begin
        if (RES_I) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign line_sync[gi] = sync_reg;
    end
  endgenerate

  assign c_sync = line_sync[0];
  assign d_sync = line_sync[1];
  assign fall   = prev_c_reg & ~c_sync;

  logic       bus_fire, wr_fire, clr_fire, rd_fire, busy, timed, frame_event;
  logic [7:0] status;

  assign bus_fire     = CYC_I & STB_I & ~ACK_O;
  assign wr_fire      = bus_fire & WE_I & ~ADR_I;
  assign clr_fire     = bus_fire & WE_I & ADR_I;
  assign rd_fire      = bus_fire & ~WE_I;
  assign busy         = (state_reg != S_IDLE);
  assign rx_inhibit_o = busy;
  assign status       = {3'b000, ovr_reg, tmo_reg, nak_reg, ackd_reg, busy};

  assign timed = (state_reg == S_BITS) || (state_reg == S_ACKW) || (state_reg == S_DONE);
  // A state-advancing event in the same cycle as expiry takes priority over the timeout.
  assign frame_event = ((state_reg == S_BITS) && fall && (bit_cnt_reg == 4'd9)) ||
                       ((state_reg == S_ACKW) && fall) ||
                       ((state_reg == S_DONE) && c_sync && d_sync);

  always_ff @(posedge CLK_I or posedge RES_I) begin
    if (RES_I) begin
      ACK_O       <= 1'b0;
      DAT_O       <= '0;
      C_OE_O      <= 1'b0;
      D_OE_O      <= 1'b0;
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      shift_reg   <= '0;
      ovr_reg     <= 1'b0;
      tmo_reg     <= 1'b0;
      nak_reg     <= 1'b0;
      ackd_reg    <= 1'b0;
      prev_c_reg  <= 1'b1;
    end else begin
      ACK_O      <= bus_fire;
      prev_c_reg <= c_sync;

      if (rd_fire) DAT_O <= ADR_I ? status : data_reg;

      if (clr_fire) begin
        if (DAT_I[4]) ovr_reg  <= 1'b0;
        if (DAT_I[3]) tmo_reg  <= 1'b0;
        if (DAT_I[2]) nak_reg  <= 1'b0;
        if (DAT_I[1]) ackd_reg <= 1'b0;
      end

      if (wr_fire) begin
        if (busy) begin
          ovr_reg <= 1'b1;
        end else begin
          data_reg  <= DAT_I;
          shift_reg <= {~^DAT_I, DAT_I};
          state_reg <= S_INHIBIT;
          cnt_reg   <= '0;
          C_OE_O    <= 1'b1;
          D_OE_O    <= 1'b0;
          tmo_reg   <= 1'b0;
          nak_reg   <= 1'b0;
          ackd_reg  <= 1'b0;
        end
      end

      case (state_reg)
        S_INHIBIT: begin
          if (cnt_reg == INH_LAST) begin
            C_OE_O      <= 1'b0;
            D_OE_O      <= 1'b1;
            state_reg   <= S_BITS;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_BITS: begin
          if (fall) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd9) begin
              D_OE_O    <= 1'b0;
              state_reg <= S_ACKW;
            end else begin
              // Eight data bits LSB first, then parity, all shifted out of one register.
              D_OE_O    <= ~shift_reg[0];
              shift_reg <= {1'b0, shift_reg[8:1]};
            end
          end
        end
        S_ACKW: begin
          if (fall) begin
            if (d_sync) nak_reg  <= 1'b1;
            else        ackd_reg <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (c_sync && d_sync) state_reg <= S_IDLE;
        end
        default: ;
      endcase

      if (timed) begin
        if (!frame_event && (cnt_reg == TMO_LAST)) begin
          tmo_reg   <= 1'b1;
          C_OE_O    <= 1'b0;
          D_OE_O    <= 1'b0;
          state_reg <= S_IDLE;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_kia_host_tx.sv
// Bench for kia_host_tx: a PS/2 device model clocks frames out of the host while a
// monitor checks bus handshake and line-release rules every cycle.
module tb_kia_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 600;
  localparam int HALF = 15;

  logic       clk, rst;
  logic       cyc, stb, we, adr;
  logic [7:0] dat_w, dat_r;
  logic       ack, c_oe, d_oe, rx_inh;
  logic       dev_c_low, dev_d_low;
  logic       c_line, d_line;
  int         tests, errors, dev_phase;

  assign c_line = ~(c_oe | dev_c_low);
  assign d_line = ~(d_oe | dev_d_low);

  kia_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(10)) dut (
    .CLK_I(clk), .RES_I(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat_w), .DAT_O(dat_r), .ACK_O(ack), .C_I(c_line), .D_I(d_line),
    .C_OE_O(c_oe), .D_OE_O(d_oe), .rx_inhibit_o(rx_inh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    cyc_wait(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    cyc_wait(1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    cyc_wait(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    cyc_wait(1);
    d = dat_r;
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Expected on-wire frame: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int  ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (rx_inh && w < 100) begin
      cyc_wait(1);
      w++;
    end
    chk(name, rx_inh, 0);
  endtask

  task automatic wait_phase(input int ph);
    int w;
    w = 0;
    while (dev_phase < ph && w < 2000) begin
      cyc_wait(1);
      w++;
    end
    chk("phase_reached", dev_phase >= ph, 1);
  endtask

  // Device model: samples the start bit after clock release, then each bit at the end of
  // the low phase following falls 1..10; optional ACK at fall 11; optional reset at a fall.
  task automatic dev_frame(input bit do_ack, input int hold, input int rst_fall,
                           output logic [10:0] got, output int nbits);
    int w;
    got = '0; nbits = 0; dev_phase = 0;
    w = 0;
    while (!c_oe && w < 100) begin cyc_wait(1); w++; end
    chk("dev_inh_seen", c_oe, 1);
    w = 0;
    while (c_oe && w < INH + 10) begin cyc_wait(1); w++; end
    chk("dev_inh_released", c_oe, 0);
    cyc_wait(5);
    got[0] = d_line; nbits = 1;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && do_ack) begin
        cyc_wait(HALF / 2);
        dev_d_low = 1'b1;
        cyc_wait(HALF - HALF / 2);
      end else begin
        cyc_wait(HALF);
      end
      dev_c_low = 1'b1;
      dev_phase = i;
      if (i == rst_fall) begin
        rst = 1'b1;
        #1;
        chk("rst_c_oe", c_oe, 0);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_rx_inh", rx_inh, 0);
        dev_c_low = 1'b0;
        return;
      end
      cyc_wait(HALF);
      if (i <= 10) begin
        got[i] = d_line;
        nbits++;
      end else begin
        cyc_wait(hold);
      end
      dev_c_low = 1'b0;
    end
    cyc_wait(HALF);
    dev_d_low = 1'b0;
  endtask

  logic [10:0] got;
  int          nb, n, w;
  logic [7:0]  s;

  initial begin
    tests = 0; errors = 0; dev_phase = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 1'b0; dat_w = '0;
    dev_c_low = 1'b0; dev_d_low = 1'b0;

    // Per-cycle monitor: ACK follows CYC&STB&~ACK; lines released whenever not busy;
    // clock inhibit lasts exactly INH cycles and hands over to a driven start bit.
    fork
      begin : monitor
        logic ack_pred;
        int   c_run;
        ack_pred = 1'b0;
        c_run = 0;
        forever begin
          @(negedge clk);
          if (rst) begin
            ack_pred = 1'b0;
            c_run = 0;
          end else begin
            chk("mon_ack", ack, ack_pred);
            ack_pred = cyc & stb & ~ack;
            if (!rx_inh) begin
              chk("mon_idle_c", c_oe, 0);
              chk("mon_idle_d", d_oe, 0);
            end
            if (c_oe) begin
              c_run++;
            end else if (c_run > 0) begin
              chk("mon_inh_len", c_run, INH);
              chk("mon_start_bit", d_oe, 1);
              c_run = 0;
            end
          end
        end
      end
    join_none

    cyc_wait(3);
    chk("reset_ack", ack, 0);
    chk("reset_dat", dat_r, 0);
    chk("reset_c_oe", c_oe, 0);
    chk("reset_d_oe", d_oe, 0);
    chk("reset_rx_inh", rx_inh, 0);
    rst = 1'b0;
    bus_read(1'b1, s); chk("reset_status", s, 8'h00);
    bus_read(1'b0, s); chk("reset_data", s, 8'h00);

    // 1: 0xED with ACK
    bus_write(1'b0, 8'hED);
    dev_frame(1'b1, 0, 0, got, nb);
    chk("t1_frame", got, exp_frame(8'hED));
    chk("t1_bits_lit", got[8:1], 8'hED);
    chk("t1_parity_lit", got[9], 1);
    chk("t1_start_stop", {got[10], got[0]}, 2'b10);
    wait_idle("t1_idle");
    bus_read(1'b1, s); chk("t1_status", s, 8'h02);

    // 2: 0x01 with NAK
    bus_write(1'b0, 8'h01);
    dev_frame(1'b0, 0, 0, got, nb);
    chk("t2_frame", got, exp_frame(8'h01));
    chk("t2_parity_lit", got[9], 0);
    wait_idle("t2_idle");
    bus_read(1'b1, s); chk("t2_status", s, 8'h04);

    // 3: 0xFF, device silent -> timeout
    bus_write(1'b0, 8'hFF);
    w = 0;
    while (c_oe && w < INH + 10) begin cyc_wait(1); w++; end
    chk("t3_inh_end", c_oe, 0);
    n = 0;
    while (d_oe && n < TMO + 50) begin cyc_wait(1); n++; end
    chk("t3_tmo_len", n, TMO);
    chk("t3_c_oe", c_oe, 0);
    chk("t3_rx_inh", rx_inh, 0);
    bus_read(1'b1, s); chk("t3_status", s, 8'h08);
    bus_write(1'b0, 8'h01);
    bus_read(1'b1, s); chk("t3_tmo_cleared", s, 8'h01);
    dev_frame(1'b1, 0, 0, got, nb);
    chk("t3_frame", got, exp_frame(8'h01));
    wait_idle("t3_idle");
    bus_read(1'b1, s); chk("t3_status2", s, 8'h02);

    // 4: overrun during BITS
    bus_write(1'b0, 8'hED);
    dev_phase = 0;
    fork
      dev_frame(1'b1, 40, 0, got, nb);
      begin
        wait_phase(3);
        bus_write(1'b0, 8'h55);
        bus_read(1'b1, s); chk("t4_ovr_busy", s, 8'h11);
        wait_phase(11);
        cyc_wait(5);
        bus_read(1'b1, s); chk("t4_status_mid", s, 8'h13);
        bus_write(1'b1, 8'h10);
        bus_read(1'b1, s); chk("t4_w1c", s, 8'h03);
      end
    join
    chk("t4_frame", got, exp_frame(8'hED));
    wait_idle("t4_idle");
    bus_read(1'b1, s); chk("t4_status_end", s, 8'h02);
    bus_read(1'b0, s); chk("t4_data", s, 8'hED);

    // 5: reset at fall 5
    bus_write(1'b0, 8'h96);
    dev_frame(1'b1, 0, 5, got, nb);
    cyc_wait(2);
    rst = 1'b0;
    chk("t5_trunc_bits", nb, 5);
    chk("t5_trunc_data", got[4:0], 5'b01100);
    bus_read(1'b1, s); chk("t5_status", s, 8'h00);
    bus_write(1'b0, 8'h3C);
    dev_frame(1'b1, 0, 0, got, nb);
    chk("t5_frame", got, exp_frame(8'h3C));
    wait_idle("t5_idle");
    bus_read(1'b1, s); chk("t5_status2", s, 8'h02);
    bus_read(1'b0, s); chk("t5_data", s, 8'h3C);

    // 6: STB held across reads, then CYC without STB
    cyc_wait(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 1'b1;
    cyc_wait(1); chk("t6_ack1", ack, 1);
    cyc_wait(1); chk("t6_ack2", ack, 0);
    cyc_wait(1); chk("t6_ack3", ack, 1);
    stb = 1'b0;
    cyc_wait(1); chk("t6_nostb1", ack, 0);
    cyc_wait(1); chk("t6_nostb2", ack, 0);
    cyc = 1'b0;
    cyc_wait(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
